// File: rtl/downsampler.sv
// rtl/downsampler.sv - symbol-rate downsampler with sync alignment and misaligned-sync counting
// Optional DOWNSAMPLER_SLICER_EN adds o_bit, the sign slice of the captured symbol.
module downsampler #(
  parameter int NB_COUNT = 2,
  parameter int NB_DATA  = 8,
  parameter int NB_ERR   = 8
) (
  input  logic                clock,
  input  logic                i_reset,
  input  logic                i_enable,
  input  logic                i_sync,
  input  logic [NB_COUNT-1:0] i_phase,
  input  logic [NB_DATA-1:0]  i_sample,
  output logic [NB_DATA-1:0]  o_symbol,
  output logic                o_valid,
  output logic                o_locked,
  output logic                o_sync_err,
  output logic [NB_ERR-1:0]   o_err_count
`ifdef DOWNSAMPLER_SLICER_EN
  ,
  output logic                o_bit
`endif
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    RUN       = 2'd2
  } state_t;

  localparam logic [NB_COUNT-1:0] CNT_ONE = NB_COUNT'(1);
  localparam logic [NB_COUNT-1:0] CNT_MAX = '1;
  localparam logic [NB_ERR-1:0]   ERR_ONE = NB_ERR'(1);
  localparam logic [NB_ERR-1:0]   ERR_MAX = '1;

  state_t              state_q, state_d;
  logic [NB_COUNT-1:0] counter_q, counter_d;
  logic [NB_COUNT-1:0] phase_q, phase_d;
  logic [NB_DATA-1:0]  symbol_q, symbol_d;
  logic                valid_q, valid_d;
  logic                locked_q, locked_d;
  logic                sync_err_q, sync_err_d;
  logic [NB_ERR-1:0]   err_q, err_d;
`ifdef DOWNSAMPLER_SLICER_EN
  logic                bit_q, bit_d;
`endif

  always_ff @(posedge clock) begin
    if (i_reset) begin
      state_q    <= IDLE;
      counter_q  <= '0;
      phase_q    <= '0;
      symbol_q   <= '0;
      valid_q    <= 1'b0;
      locked_q   <= 1'b0;
      sync_err_q <= 1'b0;
      err_q      <= '0;
`ifdef DOWNSAMPLER_SLICER_EN
      bit_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      counter_q  <= counter_d;
      phase_q    <= phase_d;
      symbol_q   <= symbol_d;
      valid_q    <= valid_d;
      locked_q   <= locked_d;
      sync_err_q <= sync_err_d;
      err_q      <= err_d;
`ifdef DOWNSAMPLER_SLICER_EN
      bit_q      <= bit_d;
`endif
    end
  end

  always_comb begin
    state_d    = state_q;
    counter_d  = counter_q;
    phase_d    = phase_q;
    symbol_d   = symbol_q;
    valid_d    = 1'b0;
    sync_err_d = 1'b0;
    err_d      = err_q;
`ifdef DOWNSAMPLER_SLICER_EN
    bit_d      = bit_q;
`endif
    if (!i_enable) begin
      state_d   = IDLE;
      counter_d = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          counter_d = '0;
          state_d   = WAIT_SYNC;
        end
        WAIT_SYNC: begin
          counter_d = '0;
          if (i_sync) begin
            state_d   = RUN;
            counter_d = CNT_ONE;
            phase_d   = i_phase;
          end
        end
        RUN: begin
          counter_d = counter_q + CNT_ONE;
          // Capture uses the pre-realign counter, so a misaligned sync never drops a due symbol.
          if (counter_q == phase_q) begin
            symbol_d = i_sample;
            valid_d  = 1'b1;
`ifdef DOWNSAMPLER_SLICER_EN
            bit_d    = ~i_sample[NB_DATA-1];
`endif
          end
          // Phase only moves at the frame boundary so each frame yields exactly one symbol.
          if (counter_q == CNT_MAX) begin
            phase_d = i_phase;
          end
          if (i_sync && (counter_q != '0)) begin
            sync_err_d = 1'b1;
            counter_d  = CNT_ONE;
            phase_d    = i_phase;
            if (err_q != ERR_MAX) begin
              err_d = err_q + ERR_ONE;
            end
          end
        end
        default: begin
          state_d   = IDLE;
          counter_d = '0;
        end
      endcase
    end
    locked_d = (state_d == RUN);
  end

  assign o_symbol    = symbol_q;
  assign o_valid     = valid_q;
  assign o_locked    = locked_q;
  assign o_sync_err  = sync_err_q;
  assign o_err_count = err_q;
`ifdef DOWNSAMPLER_SLICER_EN
  assign o_bit       = bit_q;
`endif

endmodule

// File: tb/tb_downsampler.sv
// tb/tb_downsampler.sv - directed self-checking bench for downsampler (optionally with DOWNSAMPLER_SLICER_EN)
module tb_downsampler;

  logic       clock;
  logic       i_reset;
  logic       i_enable;
  logic       i_sync;
  logic [1:0] i_phase;
  logic [7:0] i_sample;

  logic [7:0] o_symbol,  e2_symbol;
  logic       o_valid,   e2_valid;
  logic       o_locked,  e2_locked;
  logic       o_sync_err, e2_sync_err;
  logic [7:0] o_err_count;
  logic [1:0] e2_err_count;
`ifdef DOWNSAMPLER_SLICER_EN
  logic       o_bit, e2_bit;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;

  downsampler #(.NB_COUNT(2), .NB_DATA(8), .NB_ERR(8)) u_dut (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_sync(i_sync),
    .i_phase(i_phase), .i_sample(i_sample),
    .o_symbol(o_symbol), .o_valid(o_valid), .o_locked(o_locked),
    .o_sync_err(o_sync_err), .o_err_count(o_err_count)
`ifdef DOWNSAMPLER_SLICER_EN
    , .o_bit(o_bit)
`endif
  );

  downsampler #(.NB_COUNT(2), .NB_DATA(8), .NB_ERR(2)) u_dut_e2 (
    .clock(clock), .i_reset(i_reset), .i_enable(i_enable), .i_sync(i_sync),
    .i_phase(i_phase), .i_sample(i_sample),
    .o_symbol(e2_symbol), .o_valid(e2_valid), .o_locked(e2_locked),
    .o_sync_err(e2_sync_err), .o_err_count(e2_err_count)
`ifdef DOWNSAMPLER_SLICER_EN
    , .o_bit(e2_bit)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Advance one clock; inputs set afterwards apply to the new cycle, outputs reflect the edge just taken.
  task automatic step();
    @(posedge clock);
    #1;
    cyc++;
    i_sample = cyc[7:0];
  endtask

  int t0, s, u;
  logic vseen, lseen;

  initial begin
    i_reset = 1'b1; i_enable = 1'b0; i_sync = 1'b0; i_phase = 2'd0; i_sample = 8'd0;
    step(); step();
    check("rst_locked", 32'(o_locked), 32'd0);
    check("rst_valid", 32'(o_valid), 32'd0);
    check("rst_symbol", 32'(o_symbol), 32'd0);
    check("rst_sync_err", 32'(o_sync_err), 32'd0);
    check("rst_err_count", 32'(o_err_count), 32'd0);

    // 1: enabled but no sync
    i_reset = 1'b0; i_enable = 1'b1; i_phase = 2'd2;
    vseen = 1'b0; lseen = 1'b0;
    repeat (20) begin
      step();
      vseen |= o_valid;
      lseen |= o_locked;
    end
    check("nosync_valid", 32'(vseen), 32'd0);
    check("nosync_locked", 32'(lseen), 32'd0);
    check("nosync_symbol", 32'(o_symbol), 32'd0);

    // 2: sync, phase 2
    i_sync = 1'b1; t0 = cyc;
    step(); i_sync = 1'b0;
    check("lock_t1", 32'(o_locked), 32'd1);
    check("lock_valid_t1", 32'(o_valid), 32'd0);
    step();
    check("lock_valid_t2", 32'(o_valid), 32'd0);
    step();
    check("first_valid", 32'(o_valid), 32'd1);
    check("first_symbol", 32'(o_symbol), 32'((t0 + 2) & 255));
    for (int k = 1; k <= 2; k++) begin
      vseen = 1'b0;
      repeat (3) begin step(); vseen |= o_valid; end
      check("gap_valid", 32'(vseen), 32'd0);
      step();
      check("frame_valid", 32'(o_valid), 32'd1);
      check("frame_symbol", 32'(o_symbol), 32'((t0 + 2 + 4 * k) & 255));
    end

    // 3: mid-frame phase change 2 -> 0 at position 1
    step(); step();
    i_phase = 2'd0;
    step(); step();
    check("ph_old_valid", 32'(o_valid), 32'd1);
    check("ph_old_symbol", 32'(o_symbol), 32'((t0 + 14) & 255));
    step();
    check("ph_gap_valid", 32'(o_valid), 32'd0);
    step();
    check("ph_new_valid", 32'(o_valid), 32'd1);
    check("ph_new_symbol", 32'(o_symbol), 32'((t0 + 16) & 255));
    vseen = 1'b0;
    repeat (3) begin step(); vseen |= o_valid; end
    check("ph_steady_gap", 32'(vseen), 32'd0);
    step();
    check("ph_steady_valid", 32'(o_valid), 32'd1);
    check("ph_steady_symbol", 32'(o_symbol), 32'((t0 + 20) & 255));

    // 4: aligned, aligned, misaligned at position 3
    repeat (3) step();
    i_sync = 1'b1;
    step(); i_sync = 1'b0;
    check("al1_sync_err", 32'(o_sync_err), 32'd0);
    repeat (3) step();
    i_sync = 1'b1;
    step(); i_sync = 1'b0;
    check("al2_sync_err", 32'(o_sync_err), 32'd0);
    check("al2_err_count", 32'(o_err_count), 32'd0);
    step(); step();
    i_sync = 1'b1; i_phase = 2'd2;
    step(); i_sync = 1'b0;
    check("mis_sync_err", 32'(o_sync_err), 32'd1);
    check("mis_err_count", 32'(o_err_count), 32'd1);
    step();
    check("mis_sync_err_clr", 32'(o_sync_err), 32'd0);
    check("mis_valid_early", 32'(o_valid), 32'd0);
    step();
    check("realign_valid", 32'(o_valid), 32'd1);
    check("realign_symbol", 32'(o_symbol), 32'((t0 + 33) & 255));

    // 5: saturation of a 2-bit error counter
    i_reset = 1'b1;
    step();
    i_reset = 1'b0;
    check("sat_rst_count", 32'(e2_err_count), 32'd0);
    check("sat_rst_locked", 32'(e2_locked), 32'd0);
    step();
    i_sync = 1'b1;
    step(); i_sync = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step();
      check("sat_err_idle", 32'(e2_sync_err), 32'd0);
      i_sync = 1'b1;
      step(); i_sync = 1'b0;
      check("sat_err_pulse", 32'(e2_sync_err), 32'd1);
      check("sat_err_count", 32'(e2_err_count), 32'((k > 3) ? 3 : k));
    end
    check("wide_err_count", 32'(o_err_count), 32'd5);

    // 6: enable drop, hold, re-lock, slicer
    i_enable = 1'b0;
    step();
    check("dis_locked", 32'(o_locked), 32'd0);
    check("dis_valid", 32'(o_valid), 32'd0);
    check("dis_keep_count", 32'(o_err_count), 32'd5);
    check("dis_keep_count_e2", 32'(e2_err_count), 32'd3);
    i_enable = 1'b1;
    step();
    i_phase = 2'd2; i_sync = 1'b1; s = cyc;
    step(); i_sync = 1'b0;
    check("rl_locked", 32'(e2_locked), 32'd1);
    step(); i_sample = 8'hFB;
    step();
    check("neg_valid", 32'(o_valid), 32'd1);
    check("neg_symbol", 32'(o_symbol), 32'hFB);
`ifdef DOWNSAMPLER_SLICER_EN
    check("neg_bit", 32'(o_bit), 32'd0);
`endif
    step(); step(); step(); i_sample = 8'd7;
    step();
    check("pos_valid", 32'(e2_valid), 32'd1);
    check("pos_symbol", 32'(e2_symbol), 32'd7);
`ifdef DOWNSAMPLER_SLICER_EN
    check("pos_bit", 32'(e2_bit), 32'd1);
`endif
    step(); step();
    i_enable = 1'b0; i_sync = 1'b1;
    step(); i_sync = 1'b0; i_enable = 1'b1;
    check("drop_locked", 32'(o_locked), 32'd0);
    check("drop_valid", 32'(o_valid), 32'd0);
    check("drop_symbol", 32'(o_symbol), 32'd7);
    check("drop_sync_ignored", 32'(o_sync_err), 32'd0);
    vseen = 1'b0; lseen = 1'b0;
    repeat (8) begin step(); vseen |= o_valid; lseen |= o_locked; end
    check("reen_valid", 32'(vseen), 32'd0);
    check("reen_locked", 32'(lseen), 32'd0);
    check("reen_symbol", 32'(o_symbol), 32'd7);
    i_phase = 2'd0; i_sync = 1'b1; u = cyc;
    step(); i_sync = 1'b0;
    vseen = o_valid;
    repeat (3) begin step(); vseen |= o_valid; end
    check("ph0_no_sync_capture", 32'(vseen), 32'd0);
    step();
    check("ph0_valid", 32'(o_valid), 32'd1);
    check("ph0_symbol", 32'(o_symbol), 32'((u + 4) & 255));
`ifdef DOWNSAMPLER_SLICER_EN
    check("ph0_bit", 32'(o_bit), 32'(((u + 4) & 128) == 0));
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
